// File: rtl/operand_aligner.sv
// Exponent-alignment stage: picks the larger operand and right-shifts the smaller
// significand one bit per cycle, collecting guard/round/sticky bits. Optional: OPERAND_ALIGNER_SUBNORMAL_EN.
module operand_aligner #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 23,
   parameter int ROUNDING_BITS  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXPONENT_WIDTH-1:0] a_exponent,
   input  logic [MANTISSA_WIDTH-1:0] a_mantissa,
   input  logic [EXPONENT_WIDTH-1:0] b_exponent,
   input  logic [MANTISSA_WIDTH-1:0] b_mantissa,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXPONENT_WIDTH-1:0] out_exponent,
   output logic [MANTISSA_WIDTH:0]   out_large_mantissa,
   output logic [MANTISSA_WIDTH:0]   out_small_mantissa,
   output logic [ROUNDING_BITS-1:0]  out_rounding_bits,
   output logic                      out_swapped
);

   localparam int SW  = MANTISSA_WIDTH + 1;
   localparam int CAP = SW + ROUNDING_BITS;
   localparam int CW  = ($clog2(CAP + 1) > EXPONENT_WIDTH) ? $clog2(CAP + 1) : EXPONENT_WIDTH;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                    state;
   logic [CW-1:0]             count;
   logic [CAP-1:0]            shreg;

   logic [EXPONENT_WIDTH-1:0] a_eff, b_eff, e_large, e_small, diff;
   logic [SW-1:0]             a_sig, b_sig, sig_large, sig_small;
   logic                      a_large;
   logic [CW-1:0]             load_count;

   always_comb begin
`ifdef OPERAND_ALIGNER_SUBNORMAL_EN
      a_eff = (a_exponent == '0) ? EXPONENT_WIDTH'(1) : a_exponent;
      b_eff = (b_exponent == '0) ? EXPONENT_WIDTH'(1) : b_exponent;
      a_sig = {(a_exponent != '0), a_mantissa};
      b_sig = {(b_exponent != '0), b_mantissa};
`else
      a_eff = a_exponent;
      b_eff = b_exponent;
      a_sig = (a_exponent == '0) ? '0 : {1'b1, a_mantissa};
      b_sig = (b_exponent == '0) ? '0 : {1'b1, b_mantissa};
`endif
      // a wins a full tie, so out_swapped stays 0 for identical operands
      a_large    = (a_eff > b_eff) || ((a_eff == b_eff) && (a_sig >= b_sig));
      e_large    = a_large ? a_eff : b_eff;
      e_small    = a_large ? b_eff : a_eff;
      sig_large  = a_large ? a_sig : b_sig;
      sig_small  = a_large ? b_sig : a_sig;
      diff       = e_large - e_small;
      load_count = (CW'(diff) > CW'(CAP)) ? CW'(CAP) : CW'(diff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         count              <= '0;
         shreg              <= '0;
         out_exponent       <= '0;
         out_large_mantissa <= '0;
         out_swapped        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  out_exponent       <= e_large;
                  out_large_mantissa <= sig_large;
                  out_swapped        <= ~a_large;
                  shreg              <= {sig_small, {ROUNDING_BITS{1'b0}}};
                  count              <= load_count;
                  state              <= (load_count == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               // bit 0 is sticky: it absorbs everything shifted past it
               shreg <= {1'b0, shreg[CAP-1:2], shreg[1] | shreg[0]};
               count <= count - CW'(1);
               if (count == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready           = (state == IDLE);
   assign out_valid          = (state == DONE);
   assign out_small_mantissa = shreg[CAP-1:ROUNDING_BITS];
   assign out_rounding_bits  = shreg[ROUNDING_BITS-1:0];

endmodule

// File: tb/tb_operand_aligner.sv
// Directed table-driven bench for operand_aligner (default parameters),
// plus backpressure and mid-shift reset sequences.
module tb_operand_aligner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_swapped;
   logic [7:0]  a_exponent, b_exponent, out_exponent;
   logic [22:0] a_mantissa, b_mantissa;
   logic [23:0] out_large_mantissa, out_small_mantissa;
   logic [2:0]  out_rounding_bits;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   operand_aligner dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_exponent(a_exponent), .a_mantissa(a_mantissa),
      .b_exponent(b_exponent), .b_mantissa(b_mantissa),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_exponent(out_exponent),
      .out_large_mantissa(out_large_mantissa),
      .out_small_mantissa(out_small_mantissa),
      .out_rounding_bits(out_rounding_bits),
      .out_swapped(out_swapped)
   );

   typedef struct {
      logic [7:0]  ae;
      logic [22:0] am;
      logic [7:0]  be;
      logic [22:0] bm;
      logic [7:0]  oe;
      logic [23:0] ol;
      logic [23:0] os;
      logic [2:0]  rb;
      logic        sw;
      int          lat;
   } vec_t;

   vec_t vt[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept one operand pair, measure latency, check results; hold out_ready low for 'hold' cycles.
   task automatic run_vec(input vec_t v, input int hold);
      int lat;
      logic [7:0]  se;
      logic [23:0] sl, ss;
      logic [2:0]  sr;
      logic        ssw;
      @(negedge clk);
      a_exponent = v.ae; a_mantissa = v.am;
      b_exponent = v.be; b_mantissa = v.bm;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(v.lat));
      check("out_exponent", 64'(out_exponent), 64'(v.oe));
      check("large_mantissa", 64'(out_large_mantissa), 64'(v.ol));
      check("small_mantissa", 64'(out_small_mantissa), 64'(v.os));
      check("rounding_bits", 64'(out_rounding_bits), 64'(v.rb));
      check("swapped", 64'(out_swapped), 64'(v.sw));
      check("in_ready_busy", 64'(in_ready), 64'd0);
      se = out_exponent; sl = out_large_mantissa; ss = out_small_mantissa;
      sr = out_rounding_bits; ssw = out_swapped;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a_exponent = 8'd5; b_exponent = 8'd250;
         a_mantissa = 23'h7FFFFF; b_mantissa = 23'h0;
         @(posedge clk);
         #1;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_data", {out_exponent, out_large_mantissa, out_small_mantissa, out_rounding_bits, out_swapped},
               {se, sl, ss, sr, ssw});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
      check("post_hs_out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      vt[0] = '{8'd130, 23'h0, 8'd128, 23'h400000, 8'd130, 24'h800000, 24'h300000, 3'b000, 1'b0, 2};
      vt[1] = '{8'd127, 23'h0, 8'd152, 23'h0, 8'd152, 24'h800000, 24'h0, 3'b010, 1'b1, 25};
      vt[2] = '{8'd200, 23'h0, 8'd1, 23'h1, 8'd200, 24'h800000, 24'h0, 3'b001, 1'b0, 27};
      vt[3] = '{8'd100, 23'h5, 8'd100, 23'h9, 8'd100, 24'h800009, 24'h800005, 3'b000, 1'b1, 0};
      vt[4] = '{8'd10, 23'h7FFFFF, 8'd9, 23'h1, 8'd10, 24'hFFFFFF, 24'h400000, 3'b100, 1'b0, 1};
      vt[5] = '{8'd50, 23'h7, 8'd53, 23'h0, 8'd53, 24'h800000, 24'h100000, 3'b111, 1'b1, 3};
      vt[6] = '{8'd77, 23'h123456, 8'd77, 23'h123456, 8'd77, 24'h923456, 24'h923456, 3'b000, 1'b0, 0};
      vt[7] = '{8'd100, 23'h3, 8'd126, 23'h0, 8'd126, 24'h800000, 24'h0, 3'b001, 1'b1, 26};
      vt[8] = '{8'd127, 23'h0, 8'd100, 23'h0, 8'd127, 24'h800000, 24'h0, 3'b001, 1'b0, 27};
`ifdef OPERAND_ALIGNER_SUBNORMAL_EN
      vt[9] = '{8'd0, 23'h400000, 8'd2, 23'h0, 8'd2, 24'h800000, 24'h200000, 3'b000, 1'b1, 1};
`else
      vt[9] = '{8'd0, 23'h400000, 8'd2, 23'h0, 8'd2, 24'h800000, 24'h0, 3'b000, 1'b1, 2};
`endif

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_exponent = '0; a_mantissa = '0; b_exponent = '0; b_mantissa = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_data", {out_exponent, out_large_mantissa, out_small_mantissa, out_rounding_bits, out_swapped}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vt[i], 0);

      // backpressure: DONE held for 5 cycles while a new pair is offered
      run_vec(vt[0], 5);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("no_phantom_start", 64'(in_ready), 64'd1);
      end

      // reset in the middle of a 25-cycle shift
      @(negedge clk);
      a_exponent = 8'd127; a_mantissa = '0; b_exponent = 8'd152; b_mantissa = '0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_shift_busy", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_data", {out_exponent, out_small_mantissa, out_rounding_bits}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
         end
         check("abort_no_output", 64'(seen), 64'd0);
         check("abort_idle", 64'(in_ready), 64'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
